// File: rtl/sap_pkg.sv
// Shared definitions for the SAP accumulator core: opcodes, FSM states, ALU ops.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalted
    } state_e;

    typedef enum logic [1:0] {
        AluPass,
        AluAdd,
        AluSub,
        AluAnd
    } alu_op_e;

endpackage

// File: rtl/sap_alu.sv
// Combinational ALU for the SAP core: add, subtract (borrow as carry), AND, pass-through.
module sap_alu import sap_pkg::*; #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] ext;

    // One extra bit holds the carry out of ADD and the borrow out of SUB.
    always_comb begin
        ext = {1'b0, b};
        case (op)
            AluAdd:  ext = {1'b0, a} + {1'b0, b};
            AluSub:  ext = {1'b0, a} - {1'b0, b};
            AluAnd:  ext = {1'b0, a & b};
            default: ext = {1'b0, b};
        endcase
    end

    assign result = ext[DATA_W-1:0];
    assign carry  = ext[DATA_W];
    assign zero   = (result == '0);

endmodule

// File: rtl/sap_cpu.sv
// SAP accumulator processor: two-cycle FETCH/EXEC machine with muxed datapath and run-enable.
module sap_cpu import sap_pkg::*; #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              flag_c,
    output logic              flag_z
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        ir_op_q, ir_op_d;
    logic [ADDR_W-1:0] ir_arg_q, ir_arg_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_zero;

    // Only the opcode and operand fields of the instruction word are kept.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            ir_op_q     <= '0;
            ir_arg_q    <= '0;
            acc_q       <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_op_q     <= ir_op_d;
            ir_arg_q    <= ir_arg_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            z_q         <= z_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        alu_op = AluPass;
        case (ir_op_q)
            OP_ADD:  alu_op = AluAdd;
            OP_SUB:  alu_op = AluSub;
            OP_AND:  alu_op = AluAnd;
            default: alu_op = AluPass;
        endcase
    end

    assign alu_b = (ir_op_q == OP_LDI) ? {{(DATA_W - ADDR_W){1'b0}}, ir_arg_q} : mem_rdata;

    sap_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (acc_q),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_op_d     = ir_op_q;
        ir_arg_d    = ir_arg_q;
        acc_d       = acc_q;
        c_d         = c_q;
        z_d         = z_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (run) begin
            case (state_q)
                StFetch: begin
                    ir_op_d  = mem_rdata[DATA_W-1 -: 4];
                    ir_arg_d = mem_rdata[ADDR_W-1:0];
                    pc_d     = pc_q + ADDR_W'(1);
                    state_d  = StExec;
                end
                StExec: begin
                    state_d = StFetch;
                    case (ir_op_q)
                        OP_LDA, OP_LDI: begin
                            acc_d = alu_res;
                            z_d   = alu_zero;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            acc_d = alu_res;
                            z_d   = alu_zero;
                            c_d   = alu_carry;
                        end
                        OP_JMP: pc_d = ir_arg_q;
                        OP_JZ:  if (z_q) pc_d = ir_arg_q;
                        OP_JC:  if (c_q) pc_d = ir_arg_q;
                        OP_OUT: begin
                            out_d       = acc_q;
                            out_valid_d = 1'b1;
                        end
                        OP_HLT: state_d = StHalted;
                        default: ;
                    endcase
                end
                default: state_d = StHalted;
            endcase
        end
    end

    // Gating with clr keeps a write from landing on the edge that aborts it.
    assign mem_we    = run && !clr && (state_q == StExec) && (ir_op_q == OP_STA);
    assign mem_addr  = (state_q == StExec) ? ir_arg_q : pc_q;
    assign mem_wdata = acc_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q && run;
    assign halted    = (state_q == StHalted);
    assign flag_c    = c_q;
    assign flag_z    = z_q;

endmodule

// File: tb/tb_sap_cpu.sv
// Directed bench for sap_cpu: 8-bit/4-bit and 12-bit/6-bit instances, OUT values scoreboarded.
module tb_sap_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 8-bit data / 4-bit address instance
    logic        clr8, run8;
    logic [3:0]  addr8;
    logic [7:0]  rdata8, wdata8, out8;
    logic        we8, valid8, halted8, c8, z8;
    logic [7:0]  mem8 [16];
    logic [7:0]  q8 [$];

    // 12-bit data / 6-bit address instance
    logic        clr12, run12;
    logic [5:0]  addr12;
    logic [11:0] rdata12, wdata12, out12;
    logic        we12, valid12, halted12, c12, z12;
    logic [11:0] mem12 [64];
    logic [11:0] q12 [$];

    sap_cpu #(.DATA_W(8), .ADDR_W(4)) dut8 (
        .clk(clk), .clr(clr8), .run(run8), .mem_addr(addr8), .mem_rdata(rdata8),
        .mem_wdata(wdata8), .mem_we(we8), .out_data(out8), .out_valid(valid8),
        .halted(halted8), .flag_c(c8), .flag_z(z8)
    );

    sap_cpu #(.DATA_W(12), .ADDR_W(6)) dut12 (
        .clk(clk), .clr(clr12), .run(run12), .mem_addr(addr12), .mem_rdata(rdata12),
        .mem_wdata(wdata12), .mem_we(we12), .out_data(out12), .out_valid(valid12),
        .halted(halted12), .flag_c(c12), .flag_z(z12)
    );

    assign rdata8  = mem8[addr8];
    assign rdata12 = mem12[addr12];

    always @(posedge clk) begin
        if (we8)  mem8[addr8]   = wdata8;
        if (we12) mem12[addr12] = wdata12;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every out_valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (valid8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out8_unexpected: got %0h expected no pulse", out8);
            end else begin
                check("out8", {24'h0, out8}, {24'h0, q8.pop_front()});
            end
        end
        if (valid12 === 1'b1) begin
            if (q12.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out12_unexpected: got %0h expected no pulse", out12);
            end else begin
                check("out12", {20'h0, out12}, {20'h0, q12.pop_front()});
            end
        end
    end

    task automatic wait_halt8(input int limit, input string name);
        for (int i = 0; i < limit && halted8 !== 1'b1; i++) @(negedge clk);
        check(name, halted8, 1);
    endtask

    task automatic clear_mem8();
        foreach (mem8[i]) mem8[i] = 8'h00;
    endtask

    initial begin
        clr8 = 1'b1; run8 = 1'b1;
        clr12 = 1'b1; run12 = 1'b1;
        foreach (mem12[i]) mem12[i] = 12'h000;

        // Test 1: LDA 9; ADD A; OUT; HLT
        clear_mem8();
        mem8[0] = 8'h09; mem8[1] = 8'h1A; mem8[2] = 8'h80; mem8[3] = 8'hF0;
        mem8[9] = 8'h05; mem8[10] = 8'h03;
        q8.push_back(8'h08);
        @(negedge clk);
        check("rst_addr", addr8, 0);
        check("rst_out", out8, 0);
        check("rst_valid", valid8, 0);
        check("rst_halted", halted8, 0);
        check("rst_flags", {c8, z8}, 0);
        check("rst_we", we8, 0);
        clr8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", i), valid8, (i == 6) ? 1 : 0);
            check($sformatf("t1_halted_c%0d", i), halted8, (i == 8) ? 1 : 0);
        end
        check("t1_out_hold", out8, 8'h08);
        check("t1_flags", {c8, z8}, 0);
        check("t1_halt_addr", addr8, 4);
        check("t1_queue", q8.size(), 0);

        // Test 2: LDI/SUB borrow, JZ taken then not, JC taken, AND, HLT wraps PC
        clr8 = 1'b1;
        clear_mem8();
        mem8[0] = 8'h54; mem8[1] = 8'h01; mem8[4] = 8'h40; mem8[5] = 8'h68;
        mem8[6] = 8'hF0; mem8[7] = 8'h3C; mem8[8] = 8'h21; mem8[9] = 8'h80;
        mem8[10] = 8'h6E; mem8[11] = 8'h7D; mem8[12] = 8'hF0; mem8[13] = 8'h97;
        mem8[14] = 8'h80; mem8[15] = 8'hF0;
        q8.push_back(8'hFF);
        q8.push_back(8'h3C);
        @(negedge clk);
        clr8 = 1'b0;
        repeat (4) @(negedge clk);
        check("t2_ldi0_flags", {c8, z8}, 2'b01);
        repeat (2) @(negedge clk);
        check("t2_jz_taken", addr8, 8);
        repeat (2) @(negedge clk);
        check("t2_sub_flags", {c8, z8}, 2'b10);
        wait_halt8(40, "t2_halt");
        check("t2_wrap_addr", addr8, 0);
        check("t2_and_flags", {c8, z8}, 0);
        check("t2_queue", q8.size(), 0);

        // Test 3: ADD overflow, STA with run stall, STA into next instruction
        clr8 = 1'b1;
        clear_mem8();
        mem8[0] = 8'h08; mem8[1] = 8'h19; mem8[2] = 8'h3F; mem8[3] = 8'h0F;
        mem8[4] = 8'h80; mem8[5] = 8'h36; mem8[6] = 8'hF0; mem8[7] = 8'h80;
        mem8[8] = 8'hF0; mem8[9] = 8'h20;
        q8.push_back(8'h10);
        q8.push_back(8'h18);
        @(negedge clk);
        clr8 = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_add_flags", {c8, z8}, 2'b10);
        check("t3_sta_fetch_we", we8, 0);
        @(negedge clk);
        check("t3_sta_we", we8, 1);
        check("t3_sta_addr", addr8, 4'hF);
        check("t3_sta_wdata", wdata8, 8'h10);
        run8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_we", we8, 0);
            check("t3_stall_addr", addr8, 4'hF);
            check("t3_stall_c", c8, 1);
            @(negedge clk);
        end
        check("t3_stall_nowrite", mem8[15], 8'h00);
        run8 = 1'b1;
        #1;
        check("t3_resume_we", we8, 1);
        wait_halt8(40, "t3_halt");
        check("t3_mem_f", mem8[15], 8'h10);
        check("t3_mem_6", mem8[6], 8'h10);
        check("t3_halt_addr", addr8, 9);
        check("t3_final_c", c8, 0);
        check("t3_queue", q8.size(), 0);

        // Test 4: all NOPs, PC walks 0..F and wraps
        clr8 = 1'b1;
        foreach (mem8[i]) mem8[i] = 8'hA0;
        @(negedge clk);
        clr8 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            repeat (2) @(negedge clk);
            check($sformatf("t4_pc_%0d", k), addr8, k % 16);
        end
        check("t4_halted", halted8, 0);

        // Test 5: clr during STA EXEC aborts the write
        clr8 = 1'b1;
        clear_mem8();
        mem8[0] = 8'h45; mem8[1] = 8'h80; mem8[2] = 8'h3C;
        q8.push_back(8'h05);
        @(negedge clk);
        clr8 = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_pre_we", we8, 1);
        check("t5_pre_out", out8, 8'h05);
        clr8 = 1'b1;
        #1;
        check("t5_clr_we", we8, 0);
        check("t5_clr_addr", addr8, 0);
        check("t5_clr_out", out8, 0);
        @(negedge clk);
        check("t5_nowrite", mem8[12], 8'h00);
        check("t5_queue", q8.size(), 0);

        // Test 6: 12-bit instance, program runs through 0x3F and wraps to 0
        mem12[0] = 12'h73E; mem12[1] = 12'h400; mem12[2] = 12'h205; mem12[3] = 12'h800;
        mem12[4] = 12'h500; mem12[5] = 12'h001; mem12[62] = 12'h300; mem12[63] = 12'h800;
        q12.push_back(12'hFFF);
        q12.push_back(12'hFFF);
        @(negedge clk);
        clr12 = 1'b0;
        for (int i = 0; i < 60 && halted12 !== 1'b1; i++) @(negedge clk);
        check("t6_halt", halted12, 1);
        check("t6_halt_addr", addr12, 1);
        check("t6_flags", {c12, z12}, 2'b10);
        check("t6_mem0", mem12[0], 12'hFFF);
        check("t6_queue", q12.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_cpu.md
# sap_cpu

Parametrised successor to the 8-bit, 4-bit-address accumulator processor. It executes a 4-bit-opcode instruction set that adds a store instruction, load-immediate, AND, carry/zero flags and conditional jumps. It uses a multiplexed internal datapath with no tristates and a run-enable instead of clock gating. The core sits between a single-port combinational-read memory and the output register consumer, and replaces the ROM-only top level in the next design generation.

## Interface
- DATA_W, 8, accumulator, memory word and output width; DATA_W >= ADDR_W+4 is required.
- ADDR_W, 4, address width (program counter, operand field, memory address).
- clk  in  1  single clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- run  in  1  1 = execute; 0 = freeze all state (stall).
- mem_addr  out  ADDR_W  memory address. Combinational from state: PC in FETCH/HALTED, operand in EXEC.
- mem_rdata  in  DATA_W  memory read data, valid in the same cycle as mem_addr.
- mem_wdata  out  DATA_W  always equals ACC.
- mem_we  out  1  write strobe; memory writes mem_wdata at the rising edge.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse, asserted when out_data is updated.
- halted  out  1  core is in HALTED.
- flag_c, flag_z  out  1 each  carry/borrow and zero flags.

## Operation
- Instruction word: opcode = mem_rdata[DATA_W-1 -: 4]; operand = mem_rdata[ADDR_W-1:0]. Bits in between are ignored.
- Opcodes:
  - 0 LDA: ACC<=M[op].
  - 1 ADD: ACC<=ACC+M[op].
  - 2 SUB: ACC<=ACC-M[op].
  - 3 STA: M[op]<=ACC.
  - 4 LDI: ACC<=zero-extended op.
  - 5 JMP: PC<=op.
  - 6 JZ: jump if Z.
  - 7 JC: jump if C.
  - 8 OUT: out_data<=ACC.
  - 9 AND: ACC<=ACC&M[op].
  - F HLT.
  - A–E: NOP.
- State machine: FETCH -> EXEC -> FETCH. HLT in EXEC moves to HALTED, which is left only by clr.
- FETCH: mem_addr=PC; IR<=mem_rdata; PC<=PC+1, modulo 2^ADDR_W (wraps to 0).
- EXEC: mem_addr=IR operand; perform the opcode. mem_we=1 only for STA in EXEC.
- Flags:
  - Z<=(new ACC==0) on LDA, LDI, ADD, SUB, AND.
  - ADD: C<=bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: C<=1 when ACC<M (unsigned borrow); the result wraps modulo 2^DATA_W.
  - AND: C<=0.
  - All other opcodes leave both flags unchanged.
- Conditional jumps test the flags as they stand at the start of EXEC, i.e. as left by the previous flag-writing instruction.
- run=0: no register, PC, IR, flag or state update; mem_we forced 0; out_valid forced 0. Outputs otherwise hold.
- Reset values: PC=0, IR=0, ACC=0, flags=0, out_data=0, out_valid=0, halted=0, state=FETCH, mem_we=0.
- A clr assertion mid-instruction aborts it immediately. No partial write completes once clr is high.

## Timing
- Every instruction takes exactly 2 run-cycles (FETCH + EXEC). HLT reaches HALTED 2 cycles after its fetch begins.
- Results (ACC, flags, PC on jump) are visible in the cycle after EXEC.
- OUT: out_data and out_valid update at the EXEC edge. out_valid is high for exactly one cycle. The 2-cycle minimum spacing guarantees two pulses never merge.
- STA to the next instruction's address: the following FETCH sees the new value.
- JMP to its own address is a legal 2-cycle infinite loop.
- In HALTED, mem_addr = PC, which points to the word after HLT.

## Structure
- Shared package sap_pkg holds:
  - opcode localparams OP_LDA..OP_HLT;
  - a state typedef: FETCH, EXEC, HALTED.
- One sub-module, sap_alu (combinational), parametrised on DATA_W:
  - inputs: a, b, op select (ADD/SUB/AND/PASS);
  - outputs: result, carry, zero.
- Core: PC, IR, ACC, flags, output register and FSM, with explicit muxes in place of bus tristates.

## Test plan
- Reset, then LDA 9; ADD A; OUT; HLT, with M[9]=0x05 and M[A]=0x03: out_data=0x08, out_valid pulse on cycle 6, halted=1 on cycle 8, C=0, Z=0.
- LDI 0; SUB 1 with M[1]=0x01: ACC=0xFF, C=1, Z=0. JC 7 jumps to 7; JZ taken only after LDI 0 (Z=1).
- ADD overflow, ACC=0xF0 plus M=0x20: ACC=0x10, C=1. Then STA F: mem_we high for exactly the EXEC cycle, mem_addr=0xF, mem_wdata=0x10.
- PC wrap: NOPs from address 0 run through 0xF, then fetch at 0x0. run=0 held for 5 cycles mid-program: no state change, mem_we=0; execution resumes identically.
- clr asserted during STA EXEC: no write, all outputs return to reset values asynchronously. Repeat with DATA_W=12, ADDR_W=6 and a program at address 0x3F wrapping to 0.
